// File: rtl/sub_pipelined_pkg.sv
// Shared types and helpers for the segmented pipelined subtractor.
// The stage record is sized by SUB_W, which is also the default width of the top.
package sub_pipelined_pkg;

   localparam int unsigned SUB_W = 128;
   localparam int unsigned SUB_S = 4;

   // A carry of 1 out of a segment means that segment produced no borrow.
   localparam logic CARRY_NO_BORROW = 1'b1;

   typedef struct packed {
      logic [SUB_W-1:0] diff;
      logic [SUB_W-1:0] op1;
      logic [SUB_W-1:0] op2;
      logic             carry;
      logic             valid;
   } sub_stage_t;

   function automatic int unsigned seg_lo(input int unsigned k, input int unsigned seg_w);
      return k * seg_w;
   endfunction

endpackage

// File: rtl/sub_segment.sv
// One SEG-bit slice of the subtractor: a + ~b + cin, with carry out.
module sub_segment #(
   parameter int unsigned SEG = 32
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] diff,
   output logic           cout
);

   assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/sub_pipelined.sv
// Segmented, pipelined w-bit subtractor (op1 - op2 mod 2^w) with valid/ready
// backpressure. One segment of the borrow chain is resolved per stage.
// Optional borrow/zero flag outputs are built when SUB_PIPELINED_FLAGS_EN is defined.
module sub_pipelined
   import sub_pipelined_pkg::*;
#(
   parameter int unsigned w = SUB_W,
   parameter int unsigned s = SUB_S
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [w-1:0] op1,
   input  logic [w-1:0] op2,
   input  logic         valid_op1,
   input  logic         valid_op2,
   output logic         op_ready,
   output logic [w-1:0] res,
   output logic         valid,
`ifdef SUB_PIPELINED_FLAGS_EN
   output logic         borrow,
   output logic         zero,
`endif
   input  logic         res_ready
);

   localparam int unsigned SEG = w / s;

   logic         adv;
   logic         accept;
   logic [w-1:0] res_q;
   logic         valid_q;
   sub_stage_t   stage_q [s];

   // The whole pipe moves in lockstep; it only freezes when a result is
   // waiting and the consumer refuses it.
   assign adv      = ~valid_q | res_ready;
   assign op_ready = adv;
   assign accept   = valid_op1 & valid_op2 & adv;

   for (genvar k = 0; k < s; k++) begin : g_stage
      logic [SEG-1:0] a_seg;
      logic [SEG-1:0] b_seg;
      logic           cin;
      logic [SEG-1:0] diff_seg;
      logic           cout_seg;
      sub_stage_t     st_d;
      sub_stage_t     st_q;

      if (k == 0) begin : g_head
         assign a_seg = op1[SEG-1:0];
         assign b_seg = op2[SEG-1:0];
         assign cin   = CARRY_NO_BORROW;

         // Stage 0 captures both full operands together with the lowest segment.
         always_comb begin
            st_d               = '0;
            st_d.diff[SEG-1:0] = diff_seg;
            st_d.op1           = op1;
            st_d.op2           = op2;
            st_d.carry         = cout_seg;
            st_d.valid         = accept;
         end
      end else begin : g_body
         assign a_seg = stage_q[k-1].op1[seg_lo(k, SEG) +: SEG];
         assign b_seg = stage_q[k-1].op2[seg_lo(k, SEG) +: SEG];
         assign cin   = stage_q[k-1].carry;

         // Later stages pass lower segments through and fill in segment k.
         always_comb begin
            st_d                             = stage_q[k-1];
            st_d.diff[seg_lo(k, SEG) +: SEG] = diff_seg;
            st_d.carry                       = cout_seg;
         end
      end

      sub_segment #(
         .SEG (SEG)
      ) u_seg (
         .a    (a_seg),
         .b    (b_seg),
         .cin  (cin),
         .diff (diff_seg),
         .cout (cout_seg)
      );

      // Stage register; reset discards any in-flight operation.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            st_q <= '0;
         end else if (adv) begin
            st_q <= st_d;
         end
      end

      assign stage_q[k] = st_q;
   end

   // Output register takes the fully resolved difference from the last stage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else if (adv) begin
         res_q   <= stage_q[s-1].diff[w-1:0];
         valid_q <= stage_q[s-1].valid;
      end
   end

   assign res   = res_q;
   assign valid = valid_q;

`ifdef SUB_PIPELINED_FLAGS_EN
   logic borrow_q;
   logic zero_q;

   // Flags are taken from the last stage so zero does not depend on res_q,
   // and are forced low for bubbles.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
      end else if (adv) begin
         borrow_q <= stage_q[s-1].valid & (stage_q[s-1].carry != CARRY_NO_BORROW);
         zero_q   <= stage_q[s-1].valid & (stage_q[s-1].diff[w-1:0] == '0);
      end
   end

   assign borrow = borrow_q;
   assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_sub_pipelined.sv
// Self-checking bench for sub_pipelined with a scoreboard queue.
// Flag outputs are checked when SUB_PIPELINED_FLAGS_EN is defined.
module tb_sub_pipelined;

   localparam int unsigned W = 128;
   localparam int unsigned S = 4;

   typedef struct {
      logic [W-1:0] res;
      logic         brw;
      logic         zr;
      int           cyc;
      logic         lat;
   } sb_entry_t;

   logic         clk;
   logic         rstn;
   logic [W-1:0] op1;
   logic [W-1:0] op2;
   logic         valid_op1;
   logic         valid_op2;
   logic         op_ready;
   logic [W-1:0] res;
   logic         valid;
   logic         res_ready;
`ifdef SUB_PIPELINED_FLAGS_EN
   logic         borrow;
   logic         zero;
`endif

   sb_entry_t sb_q [$];
   int        n_chk  = 0;
   int        n_fail = 0;
   int        cyc    = 0;
   logic      lat_chk = 1'b0;

   sub_pipelined #(
      .w (W),
      .s (S)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .op1       (op1),
      .op2       (op2),
      .valid_op1 (valid_op1),
      .valid_op2 (valid_op2),
      .op_ready  (op_ready),
      .res       (res),
      .valid     (valid),
`ifdef SUB_PIPELINED_FLAGS_EN
      .borrow    (borrow),
      .zero      (zero),
`endif
      .res_ready (res_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: samples at the falling edge, pops on handshake, pushes on accept.
   always @(negedge clk) begin
      sb_entry_t e;
      cyc++;
      if (rstn) begin
         if (valid && res_ready) begin
            if (sb_q.size() == 0) begin
               chk("stale_out", {{(W-1){1'b0}}, valid}, '0);
            end else begin
               e = sb_q.pop_front();
               chk("res", res, e.res);
`ifdef SUB_PIPELINED_FLAGS_EN
               chk("borrow", {{(W-1){1'b0}}, borrow}, {{(W-1){1'b0}}, e.brw});
               chk("zero", {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, e.zr});
`endif
               if (e.lat)
                  chk("latency", W'(cyc - e.cyc), W'(S + 1));
            end
         end else if (valid && !res_ready) begin
            chk("stall_op_ready", {{(W-1){1'b0}}, op_ready}, '0);
            if (sb_q.size() != 0)
               chk("stall_res_hold", res, sb_q[0].res);
         end
         if (valid_op1 && valid_op2 && op_ready) begin
            e.res = op1 - op2;
            e.brw = (op1 < op2);
            e.zr  = (op1 == op2);
            e.cyc = cyc;
            e.lat = lat_chk;
            sb_q.push_back(e);
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      op1       = a;
      op2       = b;
      valid_op1 = 1'b1;
      valid_op2 = 1'b1;
      @(negedge clk);
      while (!op_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!op_ready)
         chk("send_timeout", {{(W-1){1'b0}}, op_ready}, {{(W-1){1'b0}}, 1'b1});
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      valid_op1 = 1'b0;
      valid_op2 = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("drain", W'(sb_q.size()), '0);
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_res"}, res, '0);
      chk({tag, "_valid"}, {{(W-1){1'b0}}, valid}, '0);
      chk({tag, "_op_ready"}, {{(W-1){1'b0}}, op_ready}, {{(W-1){1'b0}}, 1'b1});
`ifdef SUB_PIPELINED_FLAGS_EN
      chk({tag, "_borrow"}, {{(W-1){1'b0}}, borrow}, '0);
      chk({tag, "_zero"}, {{(W-1){1'b0}}, zero}, '0);
`endif
   endtask

   initial begin
      logic [W-1:0] a;
      int           n;

      rstn      = 1'b0;
      op1       = '0;
      op2       = '0;
      valid_op1 = 1'b0;
      valid_op2 = 1'b0;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      chk_reset_state("reset");

      // Basic and cross-segment borrow, both with latency checks.
      lat_chk = 1'b1;
      send(5, 1);
      idle();
      wait_drain();
      a = 1;
      a = a << 96;
      send(a, 1);
      idle();
      lat_chk = 1'b0;
      wait_drain();

      // Underflow then exact-zero difference.
      send(0, 1);
      send(128'hDEAD, 128'hDEAD);
      idle();
      wait_drain();

      // A lone valid must never be accepted.
      op1 = 77;
      op2 = 7;
      valid_op1 = 1'b1;
      repeat (3) @(posedge clk);
      #2 valid_op1 = 1'b0;
      valid_op2 = 1'b1;
      repeat (3) @(posedge clk);
      #2 valid_op2 = 1'b0;
      repeat (8) @(posedge clk);
      #2 chk("lone_valid", {{(W-1){1'b0}}, valid}, '0);

      // Back-to-back ops with a 3-cycle consumer stall once results appear.
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(W'(i + 10), W'(i));
            idle();
         end
         begin
            n = 0;
            @(negedge clk);
            while (!valid && n < 50) begin
               n++;
               @(negedge clk);
            end
            chk("bp_valid_seen", {{(W-1){1'b0}}, valid}, {{(W-1){1'b0}}, 1'b1});
            @(posedge clk);
            #2 res_ready = 1'b0;
            repeat (3) @(posedge clk);
            #2 res_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset between edges while three ops are in flight.
      send(30, 3);
      send(40, 4);
      send(50, 5);
      idle();
      repeat (2) @(posedge clk);
      #3 rstn = 1'b0;
      sb_q.delete();
      #1 chk("mid_rst_valid", {{(W-1){1'b0}}, valid}, '0);
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      chk_reset_state("mid_rst");
      repeat (10) @(posedge clk);
      #2 chk("mid_rst_quiet", {{(W-1){1'b0}}, valid}, '0);

      // Reset while a result is held high by a stall: valid must drop at once.
      res_ready = 1'b0;
      send(100, 1);
      idle();
      n = 0;
      @(negedge clk);
      while (!valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("async_pre_valid", {{(W-1){1'b0}}, valid}, {{(W-1){1'b0}}, 1'b1});
      #2 rstn = 1'b0;
      sb_q.delete();
      #1 chk("async_valid", {{(W-1){1'b0}}, valid}, '0);
      chk("async_res", res, '0);
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      res_ready = 1'b1;
      chk("async_op_ready", {{(W-1){1'b0}}, op_ready}, {{(W-1){1'b0}}, 1'b1});
      repeat (10) @(posedge clk);
      #2 chk("async_quiet", {{(W-1){1'b0}}, valid}, '0);

      // Random operands under random backpressure.
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               if (i % 5 == 0)
                  send({$urandom(), $urandom(), $urandom(), $urandom()},
                       {$urandom(), $urandom(), $urandom(), $urandom()});
               else
                  send({$urandom(), $urandom(), $urandom(), $urandom()},
                       {$urandom(), $urandom(), $urandom(), $urandom()} >> $urandom_range(0, 127));
            end
            idle();
         end
         begin
            for (int j = 0; j < 60; j++) begin
               res_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #2;
            end
            res_ready = 1'b1;
         end
      join
      wait_drain();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
